// File: rtl/bus_pkg.sv
// Shared bus types: split entry states and id widths.
// Used by bus_split_controller and split_entry.
package bus_pkg;

   localparam int NUM_MASTERS = 2;
   localparam int NUM_SLAVES  = 3;

   typedef logic [$clog2(NUM_MASTERS)-1:0] master_id_t;
   typedef logic [$clog2(NUM_SLAVES)-1:0]  slave_id_t;

   typedef enum logic [1:0] {
      EMPTY      = 2'd0,
      SPLIT_WAIT = 2'd1,
      RESUME     = 2'd2
   } split_state_t;

endpackage

// File: rtl/split_entry.sv
// One split entry: EMPTY -> SPLIT_WAIT -> RESUME -> EMPTY.
// Optional pending timeout with `define SPLIT_TIMEOUT_EN.
module split_entry #(
   parameter int NUM_MASTERS    = 2,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8,
   localparam int MID_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic                   CLK,
   input  logic                   RSTN,
   input  logic                   capture,
   input  logic [MID_W-1:0]       cap_mid,
   input  logic                   sbsy,
   input  logic [NUM_MASTERS-1:0] grant,
   output logic                   pend,
   output logic [NUM_MASTERS-1:0] wait_vec,
   output logic [NUM_MASTERS-1:0] resume_vec,
   output logic [NUM_MASTERS-1:0] err_evt
);
   import bus_pkg::*;

   split_state_t           state_q;
   logic [MID_W-1:0]       mid_q;
   logic [NUM_MASTERS-1:0] mid_oh;
   logic                   granted;
   logic                   timeout;

   assign mid_oh  = NUM_MASTERS'(1) << mid_q;
   assign granted = |(grant & mid_oh);

`ifdef SPLIT_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q;

   // A completing grant on the same edge beats the timeout
   assign timeout = (state_q != EMPTY)
                 && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))
                 && !((state_q == RESUME) && granted);

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN)
         cnt_q <= '0;
      else if (state_q == EMPTY)
         cnt_q <= '0;
      else
         cnt_q <= cnt_q + 1'b1;
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= EMPTY;
         mid_q   <= '0;
      end else if (timeout) begin
         state_q <= EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (capture) begin
                  state_q <= SPLIT_WAIT;
                  mid_q   <= cap_mid;
               end
            end
            SPLIT_WAIT: if (!sbsy) state_q <= RESUME;
            RESUME:     if (granted) state_q <= EMPTY;
            default:    state_q <= EMPTY;
         endcase
      end
   end

   assign pend       = (state_q != EMPTY);
   assign wait_vec   = (state_q == SPLIT_WAIT) ? mid_oh : '0;
   assign resume_vec = (state_q == RESUME) ? mid_oh : '0;
   assign err_evt    = timeout ? mid_oh : '0;

endmodule

// File: rtl/bus_split_controller.sv
// Split-transaction bookkeeping, one entry per slave.
// Optional pending timeout with `define SPLIT_TIMEOUT_EN.
module bus_split_controller #(
   parameter int NUM_MASTERS    = 2,
   parameter int NUM_SLAVES     = 3,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8,
   localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
   localparam int MID_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic                   CLK,
   input  logic                   RSTN,
   input  logic [NUM_MASTERS-1:0] B_GRANT,
   input  logic                   B_UTIL,
   input  logic [SEL_W-1:0]       B_SLAVE_SEL,
   input  logic [NUM_SLAVES-1:0]  S_SPLIT,
   input  logic [NUM_SLAVES-1:0]  B_SBSY,
   output logic                   B_SPLIT,
   output logic [NUM_MASTERS-1:0] REQ_MASK,
   output logic [NUM_MASTERS-1:0] RESUME_REQ,
   output logic [NUM_MASTERS-1:0] SPLIT_ERR,
   output logic [NUM_SLAVES-1:0]  SPLIT_PEND
);
   import bus_pkg::*;

   logic                   sel_split;
   logic                   cap_ok;
   logic [MID_W-1:0]       cap_mid;
   logic [NUM_SLAVES-1:0]  cap_vec;
   logic [NUM_SLAVES-1:0]  pend;
   logic                   accept;
   logic [NUM_MASTERS-1:0] collide_err;
   logic [NUM_MASTERS-1:0] wait_or;
   logic [NUM_MASTERS-1:0] resume_or;
   logic [NUM_MASTERS-1:0] to_err_or;
   logic [NUM_MASTERS-1:0] wait_v   [NUM_SLAVES];
   logic [NUM_MASTERS-1:0] resume_v [NUM_SLAVES];
   logic [NUM_MASTERS-1:0] err_v    [NUM_SLAVES];
   logic                   b_split_q;
   logic [NUM_MASTERS-1:0] split_err_q;

   // Only the addressed slave's split line counts, and only with a one-hot grant
   always_comb begin
      sel_split = 1'b0;
      cap_mid   = '0;
      cap_vec   = '0;
      for (int s = 0; s < NUM_SLAVES; s++)
         if (B_SLAVE_SEL == SEL_W'(s)) sel_split = S_SPLIT[s];
      for (int m = 0; m < NUM_MASTERS; m++)
         if (B_GRANT[m]) cap_mid = MID_W'(m);
      cap_ok = B_UTIL && sel_split && $onehot(B_GRANT);
      for (int s = 0; s < NUM_SLAVES; s++)
         cap_vec[s] = cap_ok && (B_SLAVE_SEL == SEL_W'(s));
   end

   assign accept      = |(cap_vec & ~pend);
   assign collide_err = (|(cap_vec & pend)) ? B_GRANT : '0;

   for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_entry
      split_entry #(
         .NUM_MASTERS   (NUM_MASTERS),
         .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
         .CNT_W         (CNT_W)
      ) u_entry (
         .CLK       (CLK),
         .RSTN      (RSTN),
         .capture   (cap_vec[s]),
         .cap_mid   (cap_mid),
         .sbsy      (B_SBSY[s]),
         .grant     (B_GRANT),
         .pend      (pend[s]),
         .wait_vec  (wait_v[s]),
         .resume_vec(resume_v[s]),
         .err_evt   (err_v[s])
      );
   end

   always_comb begin
      wait_or   = '0;
      resume_or = '0;
      to_err_or = '0;
      for (int s = 0; s < NUM_SLAVES; s++) begin
         wait_or   = wait_or   | wait_v[s];
         resume_or = resume_or | resume_v[s];
         to_err_or = to_err_or | err_v[s];
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         b_split_q   <= 1'b0;
         split_err_q <= '0;
      end else begin
         b_split_q   <= accept;
         split_err_q <= collide_err | to_err_or;
      end
   end

   assign B_SPLIT    = b_split_q;
   assign REQ_MASK   = ~wait_or;
   assign RESUME_REQ = resume_or;
   assign SPLIT_ERR  = split_err_q;
   assign SPLIT_PEND = pend;

endmodule

// File: tb/tb_bus_split_controller.sv
// Directed bench for bus_split_controller, default build.
module tb_bus_split_controller;

   logic       CLK;
   logic       RSTN;
   logic [1:0] B_GRANT;
   logic       B_UTIL;
   logic [1:0] B_SLAVE_SEL;
   logic [2:0] S_SPLIT;
   logic [2:0] B_SBSY;
   logic       B_SPLIT;
   logic [1:0] REQ_MASK;
   logic [1:0] RESUME_REQ;
   logic [1:0] SPLIT_ERR;
   logic [2:0] SPLIT_PEND;

   // {B_SPLIT, REQ_MASK, RESUME_REQ, SPLIT_ERR, SPLIT_PEND}
   logic [9:0] obs;
   assign obs = {B_SPLIT, REQ_MASK, RESUME_REQ, SPLIT_ERR, SPLIT_PEND};

   int pass_cnt = 0;
   int chk_cnt  = 0;

   bus_split_controller dut (
      .CLK        (CLK),
      .RSTN       (RSTN),
      .B_GRANT    (B_GRANT),
      .B_UTIL     (B_UTIL),
      .B_SLAVE_SEL(B_SLAVE_SEL),
      .S_SPLIT    (S_SPLIT),
      .B_SBSY     (B_SBSY),
      .B_SPLIT    (B_SPLIT),
      .REQ_MASK   (REQ_MASK),
      .RESUME_REQ (RESUME_REQ),
      .SPLIT_ERR  (SPLIT_ERR),
      .SPLIT_PEND (SPLIT_PEND)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic idle;
      B_GRANT = 2'b00; B_UTIL = 1'b0; B_SLAVE_SEL = 2'd0; S_SPLIT = 3'b000;
   endtask

   task automatic drive(input logic [1:0] g, input logic [1:0] sel,
                        input logic [2:0] sp);
      B_GRANT = g; B_UTIL = 1'b1; B_SLAVE_SEL = sel; S_SPLIT = sp;
   endtask

   task automatic test_reset;
      RSTN = 1'b0;
      idle();
      B_SBSY = 3'b111;
      repeat (2) tick();
      chk_cnt++;
      if (obs !== 10'b0_11_00_00_000)
         $display("FAIL reset_values: got %b expected %b", obs, 10'b0_11_00_00_000);
      else pass_cnt++;
      RSTN = 1'b1;
      tick();
   endtask

   task automatic test_ignore;
      drive(2'b01, 2'd1, 3'b100);
      tick();
      chk_cnt++;
      if (obs !== 10'b0_11_00_00_000)
         $display("FAIL non_selected: got %b expected %b", obs, 10'b0_11_00_00_000);
      else pass_cnt++;
      drive(2'b11, 2'd2, 3'b100);
      tick();
      chk_cnt++;
      if (obs !== 10'b0_11_00_00_000)
         $display("FAIL multi_hot_grant: got %b expected %b", obs, 10'b0_11_00_00_000);
      else pass_cnt++;
      drive(2'b00, 2'd2, 3'b100);
      tick();
      chk_cnt++;
      if (obs !== 10'b0_11_00_00_000)
         $display("FAIL zero_grant: got %b expected %b", obs, 10'b0_11_00_00_000);
      else pass_cnt++;
      drive(2'b01, 2'd2, 3'b100);
      B_UTIL = 1'b0;
      tick();
      chk_cnt++;
      if (obs !== 10'b0_11_00_00_000)
         $display("FAIL no_util: got %b expected %b", obs, 10'b0_11_00_00_000);
      else pass_cnt++;
      idle();
   endtask

   task automatic test_basic_split;
      // busy low on the capture edge itself must not resume
      drive(2'b01, 2'd2, 3'b100);
      B_SBSY = 3'b011;
      tick();
      chk_cnt++;
      if (obs !== 10'b1_10_00_00_100)
         $display("FAIL basic_capture: got %b expected %b", obs, 10'b1_10_00_00_100);
      else pass_cnt++;
      idle();
      B_SBSY = 3'b111;
      tick();
      chk_cnt++;
      if (obs !== 10'b0_10_00_00_100)
         $display("FAIL split_pulse_width: got %b expected %b", obs, 10'b0_10_00_00_100);
      else pass_cnt++;
   endtask

   task automatic test_resume;
      B_SBSY = 3'b011;
      tick();
      chk_cnt++;
      if (obs !== 10'b0_11_01_00_100)
         $display("FAIL resume_req: got %b expected %b", obs, 10'b0_11_01_00_100);
      else pass_cnt++;
      B_SBSY = 3'b111;
      tick();
      chk_cnt++;
      if (obs !== 10'b0_11_01_00_100)
         $display("FAIL resume_hold: got %b expected %b", obs, 10'b0_11_01_00_100);
      else pass_cnt++;
      B_GRANT = 2'b01;
      tick();
      chk_cnt++;
      if (obs !== 10'b0_11_00_00_000)
         $display("FAIL resume_complete: got %b expected %b", obs, 10'b0_11_00_00_000);
      else pass_cnt++;
      idle();
   endtask

   task automatic test_collision;
      drive(2'b01, 2'd1, 3'b010);
      tick();
      chk_cnt++;
      if (obs !== 10'b1_10_00_00_010)
         $display("FAIL coll_first_capture: got %b expected %b", obs, 10'b1_10_00_00_010);
      else pass_cnt++;
      drive(2'b10, 2'd1, 3'b010);
      tick();
      chk_cnt++;
      if (obs !== 10'b0_10_00_10_010)
         $display("FAIL collision_err: got %b expected %b", obs, 10'b0_10_00_10_010);
      else pass_cnt++;
      idle();
      tick();
      chk_cnt++;
      if (obs !== 10'b0_10_00_00_010)
         $display("FAIL collision_err_width: got %b expected %b", obs, 10'b0_10_00_00_010);
      else pass_cnt++;
      B_SBSY = 3'b101;
      tick();
      chk_cnt++;
      if (obs !== 10'b0_11_01_00_010)
         $display("FAIL stored_master_kept: got %b expected %b", obs, 10'b0_11_01_00_010);
      else pass_cnt++;
      B_SBSY = 3'b111;
      B_GRANT = 2'b01;
      tick();
      chk_cnt++;
      if (obs !== 10'b0_11_00_00_000)
         $display("FAIL coll_cleanup: got %b expected %b", obs, 10'b0_11_00_00_000);
      else pass_cnt++;
      idle();
   endtask

   task automatic test_concurrency;
      drive(2'b01, 2'd0, 3'b001);
      tick();
      chk_cnt++;
      if (obs !== 10'b1_10_00_00_001)
         $display("FAIL park_m0: got %b expected %b", obs, 10'b1_10_00_00_001);
      else pass_cnt++;
      drive(2'b10, 2'd2, 3'b100);
      tick();
      chk_cnt++;
      if (obs !== 10'b1_00_00_00_101)
         $display("FAIL park_both: got %b expected %b", obs, 10'b1_00_00_00_101);
      else pass_cnt++;
      idle();
      B_SBSY = 3'b010;
      tick();
      chk_cnt++;
      if (obs !== 10'b0_11_11_00_101)
         $display("FAIL both_resume: got %b expected %b", obs, 10'b0_11_11_00_101);
      else pass_cnt++;
      // m0 completes on slave 0 while splitting again on slave 1
      B_SBSY = 3'b111;
      drive(2'b01, 2'd1, 3'b010);
      tick();
      chk_cnt++;
      if (obs !== 10'b1_10_10_00_110)
         $display("FAIL capture_and_clear: got %b expected %b", obs, 10'b1_10_10_00_110);
      else pass_cnt++;
      idle();
      B_GRANT = 2'b10;
      tick();
      chk_cnt++;
      if (obs !== 10'b0_10_00_00_010)
         $display("FAIL clear_m1: got %b expected %b", obs, 10'b0_10_00_00_010);
      else pass_cnt++;
      B_GRANT = 2'b00;
      B_SBSY = 3'b101;
      tick();
      chk_cnt++;
      if (obs !== 10'b0_11_01_00_010)
         $display("FAIL resume_s1: got %b expected %b", obs, 10'b0_11_01_00_010);
      else pass_cnt++;
      B_SBSY = 3'b111;
   endtask

   task automatic test_reset_mid;
      #3;
      RSTN = 1'b0;
      #1;
      chk_cnt++;
      if (obs !== 10'b0_11_00_00_000)
         $display("FAIL async_reset: got %b expected %b", obs, 10'b0_11_00_00_000);
      else pass_cnt++;
      tick();
      RSTN = 1'b1;
      tick();
      chk_cnt++;
      if (obs !== 10'b0_11_00_00_000)
         $display("FAIL post_reset_1: got %b expected %b", obs, 10'b0_11_00_00_000);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (obs !== 10'b0_11_00_00_000)
         $display("FAIL post_reset_2: got %b expected %b", obs, 10'b0_11_00_00_000);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_ignore();
      test_basic_split();
      test_resume();
      test_collision();
      test_concurrency();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
